joyscan: RTL and testbench
==========================

Name: joyscan

Overview:
- Parametrised serial joystick scanner; successor to the fixed two-pad, 8-bit shift-register reader.
- Drives a chain of parallel-in/serial-out registers (74HC165 style) over joyCk/joyLd/joyQ.
- Handles any number of channels and bits per channel, plus optional two-phase select (joyS) scanning for 6-button pads.
- Sits beside the keyboard path in each board top. Its raw active-low bank vector feeds the machine core, which inverts it.

Parameters:
- CHANNELS, 2, number of pads in the chain.
- BITS, 8, bits per pad.
- PHASES, 1, select phases per frame: 1 = joyS held high; 2 = scan with joyS=1, then joyS=0.
- DIV, 48, system clocks per scan tick, DIV>=2 (48 gives a 1 MHz tick at 48 MHz).
- SETTLE, 8, ticks to wait after a joyS change or at frame start before LOAD.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- ena  in  1  scanning enable; sampled only at frame boundaries.
- joyCk  out  1  shift clock to the register chain.
- joyLd  out  1  parallel load, active low.
- joyS  out  1  pad select line.
- joyQ  in  1  serial data from the chain.
- data  out  PHASES*CHANNELS*BITS  committed bits, 1 = released. Bank p is at [(p+1)*N-1 : p*N], N = CHANNELS*BITS. Channel c occupies [p*N+(c+1)*BITS-1 : p*N+c*BITS] within its bank.
- valid  out  1  one-clock pulse when a full frame is committed.
- busy  out  1  high while a frame is in progress.

Behaviour:
- Reset values: joyCk=1, joyLd=1, joyS=1, data=all ones, valid=0, busy=0. The FSM is in IDLE and the tick counter is 0.
- Reset asserted mid-frame aborts immediately to the reset values. The partial shift register is discarded.
- Tick: a counter counts 0..DIV-1; `tick` is high for one clock at DIV-1. All FSM transitions except IDLE->SETTLE occur on tick.

FSM states, N = CHANNELS*BITS:
- IDLE: if ena=1, go to SETTLE on the next clock; busy=1, phase=0, joyS=1.
- SETTLE: wait SETTLE ticks, then go to LOAD.
- LOAD: joyLd=0, joyCk=0 for 1 tick, then go to SHIFT_L with bit count k=0.
- SHIFT_L: joyLd=1, joyCk=0 for 1 tick, then SHIFT_H.
- SHIFT_H: on entry, joyCk goes 1 and joyQ is sampled in that same clock into sreg (shift left, new bit at LSB). After 1 tick:
  - if k=N-1, go to COMMIT_PH;
  - otherwise k++ and go to SHIFT_L.
- Bit order: the first bit sampled lands at the bank MSB, bit N-1.
- COMMIT_PH: sreg is copied into a staging bank[phase].
  - If phase < PHASES-1: phase++, joyS=0, go to SETTLE.
  - Otherwise go to COMMIT.
- COMMIT (1 clock): staging is copied to data, valid=1 for exactly one clock, joyS=1, busy=0, then IDLE.
- Frame length in ticks: PHASES*(SETTLE+1+2N), plus 1 clock for COMMIT.
- data changes only in the COMMIT clock, so all banks update atomically.
- ena going low mid-frame: the frame completes and commits; the FSM then stays in IDLE.
- ena high continuously: frames run back to back, with IDLE lasting 1 clock.

Optional Feature:
- Macro: JOYSCAN_DEBOUNCE_EN.
- When defined: keep the previous frame's staging. In COMMIT, data updates only for banks whose staging equals the previous frame's staging; other banks keep their old value. valid still pulses every frame.
- When undefined: data is loaded unconditionally each COMMIT. No previous-staging storage is instantiated.

Decomposition:
- Package joyscan_pkg holds:
  - state enum (IDLE, SETTLE, LOAD, SHIFT_L, SHIFT_H, COMMIT_PH, COMMIT);
  - function clog2 for the counter widths;
  - localparam defaults for DIV and SETTLE.
- One sub-module, joyscan_tick: DIV tick divider with async active-low reset, output tick.

Test Plan:
- Reset and idle: reset=0, then ena=0 for 1000 clocks -> joyCk=1, joyLd=1, joyS=1, data=all ones, valid never pulses.
- Single phase, CHANNELS=2, BITS=8, chain model loaded with 16'hA53C -> exactly one valid pulse; data=16'hA53C; frame = 8+1+32 ticks + 1 clock; joyLd low for exactly DIV clocks.
- PHASES=2, model returns 16'h1234 when joyS=1 and 16'hFEDC when joyS=0 -> data[15:0]=16'h1234, data[31:16]=16'hFEDC; joyS low only during the second phase.
- ena dropped during SHIFT_H of bit 5 -> frame commits; busy falls; no new LOAD follows.
- Reset asserted during SHIFT -> all outputs return to reset values within the same clock; the next frame after release starts with SETTLE.
- With JOYSCAN_DEBOUNCE_EN, model returns 16'h00FF, 16'h0F0F, 16'h0F0F on successive frames -> data=all ones, all ones, then 16'h0F0F. Without the macro -> 16'h00FF, 16'h0F0F, 16'h0F0F.

Source files
------------

// File: rtl/joyscan_pkg.sv
// joyscan_pkg: shared types, default timing constants and width helper
// for the serial joystick scanner.
//   state_t        scanner FSM state encoding
//   clog2()        counter width helper (never returns less than 1)
//   DIV_DEFAULT    system clocks per scan tick (1 MHz at 48 MHz)
//   SETTLE_DEFAULT ticks to wait before each parallel load
package joyscan_pkg;

   localparam int unsigned DIV_DEFAULT    = 48;
   localparam int unsigned SETTLE_DEFAULT = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_LOAD,
      ST_SHIFT_L,
      ST_SHIFT_H,
      ST_COMMIT_PH,
      ST_COMMIT
   } state_t;

   // Bits needed to hold 0..v-1; at least 1 so degenerate counters stay legal.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 1;
      while ((r < 31) && ((32'd1 << r) < v)) r++;
      return r;
   endfunction

endpackage

// File: rtl/joyscan_tick.sv
// joyscan_tick: scan tick divider.
//   clock  system clock
//   reset  asynchronous active-low reset
//   clr    synchronous restart of the count at 0
//   tick   high for one clock while the count sits at DIV-1
module joyscan_tick
   import joyscan_pkg::*;
#(
   parameter int unsigned DIV = DIV_DEFAULT
)(
   input  logic clock,
   input  logic reset,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CW = clog2(DIV);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;

   // Wrapping count, forced back to 0 while cleared
   always_comb begin
      cnt_nxt = cnt + CW'(1);
      if (clr || (cnt == CW'(DIV - 1))) cnt_nxt = '0;
   end

   // tick is registered from the next count so it tracks cnt == DIV-1 exactly
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         cnt  <= cnt_nxt;
         tick <= (cnt_nxt == CW'(DIV - 1));
      end
   end

endmodule

// File: rtl/joyscan.sv
// joyscan: parametrised scanner for a chain of 74HC165-style PISO registers.
// Optional feature macro: JOYSCAN_DEBOUNCE_EN (a bank only updates when two
// consecutive frames agree on it).
//   clock  system clock
//   reset  asynchronous active-low reset
//   ena    scan enable, sampled only in IDLE
//   joyCk  shift clock to the chain
//   joyLd  parallel load to the chain, active low
//   joyS   pad select (1 = first phase, 0 = second phase)
//   joyQ   serial data from the chain
//   data   committed banks, PHASES x CHANNELS x BITS, 1 = released
//   valid  one-clock pulse when a frame is committed
//   busy   high while a frame is in progress
module joyscan
   import joyscan_pkg::*;
#(
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned BITS     = 8,
   parameter int unsigned PHASES   = 1,
   parameter int unsigned DIV      = DIV_DEFAULT,
   parameter int unsigned SETTLE   = SETTLE_DEFAULT
)(
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            ena,
   output logic                            joyCk,
   output logic                            joyLd,
   output logic                            joyS,
   input  logic                            joyQ,
   output logic [PHASES*CHANNELS*BITS-1:0] data,
   output logic                            valid,
   output logic                            busy
);

   localparam int unsigned N  = CHANNELS * BITS;
   localparam int unsigned W  = PHASES * N;
   localparam int unsigned KW = clog2(N);
   localparam int unsigned SW = clog2(SETTLE);
   localparam int unsigned PW = clog2(PHASES);

   state_t          state;
   logic [SW-1:0]   sc;
   logic [KW-1:0]   k;
   logic [PW-1:0]   phase;
   logic [N-1:0]    sreg;
   logic [W-1:0]    stage;
   logic [W-1:0]    stage_nxt;
   logic [W-1:0]    data_nxt;
   logic            tick;
   logic            tick_clr;

   // Counter restarts from IDLE so every frame has identical tick alignment
   assign tick_clr = (state == ST_IDLE);

   joyscan_tick #(
      .DIV (DIV)
   ) u_tick (
      .clock (clock),
      .reset (reset),
      .clr   (tick_clr),
      .tick  (tick)
   );

   // Staging with the bank of the current phase replaced by the shift register
   always_comb begin
      stage_nxt = stage;
      for (int p = 0; p < int'(PHASES); p++) begin
         if (PW'(p) == phase) stage_nxt[p*N +: N] = sreg;
      end
   end

`ifdef JOYSCAN_DEBOUNCE_EN
   logic [W-1:0] prev;

   // A bank is accepted only when it matches the previous frame's staging
   always_comb begin
      data_nxt = data;
      for (int p = 0; p < int'(PHASES); p++) begin
         if (stage_nxt[p*N +: N] == prev[p*N +: N]) data_nxt[p*N +: N] = stage_nxt[p*N +: N];
      end
   end

   // Previous-frame staging, captured once per completed frame
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         prev <= '1;
      end else if ((state == ST_COMMIT_PH) && (phase == PW'(PHASES - 1))) begin
         prev <= stage_nxt;
      end
   end
`else
   always_comb begin
      data_nxt = stage_nxt;
   end
`endif

   // Scan FSM; all outputs registered and set on the transition into a state
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         sc    <= '0;
         k     <= '0;
         phase <= '0;
         sreg  <= '0;
         stage <= '1;
         data  <= '1;
         valid <= 1'b0;
         busy  <= 1'b0;
         joyCk <= 1'b1;
         joyLd <= 1'b1;
         joyS  <= 1'b1;
      end else begin
         valid <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (ena) begin
                  state <= ST_SETTLE;
                  busy  <= 1'b1;
                  phase <= '0;
                  sc    <= '0;
                  joyS  <= 1'b1;
               end
            end
            ST_SETTLE: begin
               if (tick) begin
                  if (sc == SW'(SETTLE - 1)) begin
                     sc    <= '0;
                     state <= ST_LOAD;
                     joyLd <= 1'b0;
                     joyCk <= 1'b0;
                  end else begin
                     sc <= sc + SW'(1);
                  end
               end
            end
            ST_LOAD: begin
               if (tick) begin
                  state <= ST_SHIFT_L;
                  joyLd <= 1'b1;
                  k     <= '0;
               end
            end
            ST_SHIFT_L: begin
               // Q is sampled on the same clock that raises joyCk, before the chain shifts
               if (tick) begin
                  state <= ST_SHIFT_H;
                  joyCk <= 1'b1;
                  sreg  <= {sreg[N-2:0], joyQ};
               end
            end
            ST_SHIFT_H: begin
               if (tick) begin
                  if (k == KW'(N - 1)) begin
                     state <= ST_COMMIT_PH;
                  end else begin
                     k     <= k + KW'(1);
                     joyCk <= 1'b0;
                     state <= ST_SHIFT_L;
                  end
               end
            end
            ST_COMMIT_PH: begin
               // Single clock; the tick counter keeps running so the next
               // SETTLE still waits full ticks and phases stay DIV-aligned
               stage <= stage_nxt;
               if (phase == PW'(PHASES - 1)) begin
                  state <= ST_COMMIT;
                  data  <= data_nxt;
                  valid <= 1'b1;
                  joyS  <= 1'b1;
               end else begin
                  phase <= phase + PW'(1);
                  joyS  <= 1'b0;
                  state <= ST_SETTLE;
               end
            end
            ST_COMMIT: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_joyscan.sv
// tb_joyscan: scoreboard bench for joyscan. DUT a is single phase, DUT b is
// two phase; each drives a behavioural 74HC165 chain model.
module tb_joyscan;

   localparam int unsigned DIV    = 4;
   localparam int unsigned SETTLE = 8;
   localparam int unsigned N      = 16;
   localparam int unsigned PH_TICKS = SETTLE + 1 + 2*N;          // 41
   localparam int unsigned FRAME1 = PH_TICKS*DIV + 1;            // 165
   localparam int unsigned FRAME2 = 2*PH_TICKS*DIV + 1;          // 329

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic ena_a = 1'b0;
   logic ena_b = 1'b0;

   logic        ck_a, ld_a, s_a, q_a, valid_a, busy_a;
   logic [15:0] data_a;
   logic        ck_b, ld_b, s_b, q_b, valid_b, busy_b;
   logic [31:0] data_b;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   joyscan #(.CHANNELS(2), .BITS(8), .PHASES(1), .DIV(DIV), .SETTLE(SETTLE)) u_a (
      .clock(clock), .reset(reset), .ena(ena_a), .joyCk(ck_a), .joyLd(ld_a),
      .joyS(s_a), .joyQ(q_a), .data(data_a), .valid(valid_a), .busy(busy_a));

   joyscan #(.CHANNELS(2), .BITS(8), .PHASES(2), .DIV(DIV), .SETTLE(SETTLE)) u_b (
      .clock(clock), .reset(reset), .ena(ena_b), .joyCk(ck_b), .joyLd(ld_b),
      .joyS(s_b), .joyQ(q_b), .data(data_b), .valid(valid_b), .busy(busy_b));

   // Chain models: load on joyLd falling, shift toward Q on joyCk rising
   logic [15:0] word_a = 16'hFFFF, sh_a = 16'hFFFF;
   logic [15:0] word_b_hi = 16'hFFFF, word_b_lo = 16'hFFFF, sh_b = 16'hFFFF;
   logic        load_sel_b[$];
   assign q_a = sh_a[15];
   assign q_b = sh_b[15];
   always @(negedge ld_a) sh_a = word_a;
   always @(posedge ck_a) if (ld_a) sh_a = {sh_a[14:0], 1'b1};
   always @(negedge ld_b) begin
      sh_b = s_b ? word_b_hi : word_b_lo;
      load_sel_b.push_back(s_b);
   end
   always @(posedge ck_b) if (ld_b) sh_b = {sh_b[14:0], 1'b1};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected-value model of the committed data
   logic [15:0] mdl_a = 16'hFFFF;
   logic [31:0] mdl_b = 32'hFFFF_FFFF;
`ifdef JOYSCAN_DEBOUNCE_EN
   logic [15:0] prev_a = 16'hFFFF;
   logic [31:0] prev_b = 32'hFFFF_FFFF;
`endif
   logic [15:0] exp_q_a[$];
   logic [31:0] exp_q_b[$];

   task automatic model_reset();
      mdl_a = 16'hFFFF;
      mdl_b = 32'hFFFF_FFFF;
`ifdef JOYSCAN_DEBOUNCE_EN
      prev_a = 16'hFFFF;
      prev_b = 32'hFFFF_FFFF;
`endif
   endtask

   task automatic push_a(input logic [15:0] w);
`ifdef JOYSCAN_DEBOUNCE_EN
      if (w == prev_a) mdl_a = w;
      prev_a = w;
`else
      mdl_a = w;
`endif
      exp_q_a.push_back(mdl_a);
   endtask

   task automatic push_b(input logic [31:0] w);
`ifdef JOYSCAN_DEBOUNCE_EN
      for (int p = 0; p < 2; p++)
         if (w[p*16 +: 16] == prev_b[p*16 +: 16]) mdl_b[p*16 +: 16] = w[p*16 +: 16];
      prev_b = w;
`else
      mdl_b = w;
`endif
      exp_q_b.push_back(mdl_b);
   endtask

   // Monitor: scoreboard pops plus event bookkeeping, sampled on the falling edge
   int valid_cnt_a = 0, valid_cnt_b = 0, valid_cyc_a = 0, valid_cyc_b = 0;
   int busy_rise_a = 0, busy_rise_b = 0, ld_low_a = 0, ld_falls_a = 0, ld_fall_cyc_a = 0;
   int s_low_b = 0, ck_rises_a = 0;
   logic busy_a_d = 1'b0, busy_b_d = 1'b0, ld_a_d = 1'b1, ck_a_d = 1'b1;
   logic [15:0] e_a;
   logic [31:0] e_b;

   always @(negedge clock) begin
      if (valid_a) begin
         valid_cnt_a++;
         valid_cyc_a = cyc;
         if (exp_q_a.size() == 0) check("valid_a_unexpected", {16'h0, data_a}, 32'hDEAD_BEEF);
         else begin
            e_a = exp_q_a.pop_front();
            check("data_a", data_a, e_a);
         end
      end
      if (valid_b) begin
         valid_cnt_b++;
         valid_cyc_b = cyc;
         if (exp_q_b.size() == 0) check("valid_b_unexpected", {32'h0, data_b}, 64'hDEAD_BEEF_0000_0000);
         else begin
            e_b = exp_q_b.pop_front();
            check("data_b", data_b, e_b);
         end
      end
      if (busy_a && !busy_a_d) busy_rise_a = cyc;
      if (busy_b && !busy_b_d) busy_rise_b = cyc;
      if (!ld_a) ld_low_a++;
      if (ld_a_d && !ld_a) begin
         ld_falls_a++;
         ld_fall_cyc_a = cyc;
      end
      if (ck_a && !ck_a_d) ck_rises_a++;
      if (!s_b) s_low_b++;
      busy_a_d = busy_a;
      busy_b_d = busy_b;
      ld_a_d   = ld_a;
      ck_a_d   = ck_a;
   end

   task automatic step();
      @(negedge clock);
      #1;
   endtask

   task automatic wait_valid(input bit sel, input int budget, input string name);
      int start, n;
      start = sel ? valid_cnt_b : valid_cnt_a;
      n = 0;
      while (((sel ? valid_cnt_b : valid_cnt_a) == start) && (n < budget)) begin
         step();
         n++;
      end
      if ((sel ? valid_cnt_b : valid_cnt_a) == start) check(name, 64'd0, 64'd1);
   endtask

   task automatic wait_busy(input bit sel, input int budget, input string name);
      int n;
      n = 0;
      while (!(sel ? busy_b : busy_a) && (n < budget)) begin
         step();
         n++;
      end
      if (!(sel ? busy_b : busy_a)) check(name, 64'd0, 64'd1);
   endtask

   task automatic wait_ck_rises(input int target, input int budget, input string name);
      int n;
      n = 0;
      while ((ck_rises_a < target) && (n < budget)) begin
         step();
         n++;
      end
      if (ck_rises_a < target) check(name, 64'(ck_rises_a), 64'(target));
   endtask

   int base, lowc, falls, n;

   initial begin
      // Reset state
      repeat (3) step();
      check("rst_ck", ck_a, 1);
      check("rst_ld", ld_a, 1);
      check("rst_s", s_a, 1);
      check("rst_data_a", data_a, 16'hFFFF);
      check("rst_data_b", data_b, 32'hFFFF_FFFF);
      check("rst_valid", valid_a, 0);
      check("rst_busy", busy_a, 0);

      // Idle with ena low
      reset = 1'b1;
      repeat (1000) step();
      check("idle_no_valid", valid_cnt_a + valid_cnt_b, 0);
      check("idle_no_load", ld_falls_a, 0);
      check("idle_outs", {ck_a, ld_a, s_a, busy_a}, 4'b1110);
      check("idle_data", data_a, 16'hFFFF);

      // Single-phase frame
      word_a = 16'hA53C;
      push_a(16'hA53C);
      lowc = ld_low_a;
      ena_a = 1'b1;
      wait_busy(0, 10, "busy_a_start");
      ena_a = 1'b0;
      wait_valid(0, FRAME1 + 50, "valid_a_timeout");
      check("frame_len_a", valid_cyc_a - busy_rise_a, FRAME1);
      check("ld_low_len_a", ld_low_a - lowc, DIV);
      check("valid_count_a", valid_cnt_a, 1);

      // Two-phase frame
      word_b_hi = 16'h1234;
      word_b_lo = 16'hFEDC;
      push_b({16'hFEDC, 16'h1234});
      lowc = s_low_b;
      ena_b = 1'b1;
      wait_busy(1, 10, "busy_b_start");
      ena_b = 1'b0;
      wait_valid(1, FRAME2 + 50, "valid_b_timeout");
      check("frame_len_b", valid_cyc_b - busy_rise_b, FRAME2);
      check("s_low_len_b", s_low_b - lowc, PH_TICKS*DIV);
      check("loads_b", load_sel_b.size(), 2);
      if (load_sel_b.size() == 2) begin
         check("load0_sel_b", load_sel_b[0], 1);
         check("load1_sel_b", load_sel_b[1], 0);
      end
      step();
      check("s_after_b", s_b, 1);

      // ena dropped in SHIFT_H of bit 5: frame still completes, none follows
      word_a = 16'h5AC3;
      push_a(16'h5AC3);
      base  = ck_rises_a;
      falls = ld_falls_a;
      ena_a = 1'b1;
      wait_ck_rises(base + 6, 200, "bit5_timeout");
      ena_a = 1'b0;
      check("bit5_ck_high", ck_a, 1);
      wait_valid(0, FRAME1 + 50, "valid_drop_timeout");
      check("frame_len_drop", valid_cyc_a - busy_rise_a, FRAME1);
      repeat (300) step();
      check("drop_busy", busy_a, 0);
      check("drop_one_load", ld_falls_a - falls, 1);

      // Reset during SHIFT aborts; next frame starts with SETTLE
      word_a = 16'h0000;
      base = ck_rises_a;
      ena_a = 1'b1;
      wait_ck_rises(base + 3, 200, "abort_timeout");
      n = 0;
      while (ck_a && (n < 20)) begin
         step();
         n++;
      end
      check("abort_in_shift_l", ck_a, 0);
      reset = 1'b0;
      model_reset();
      #1;
      check("abort_outs", {ck_a, ld_a, s_a, busy_a, valid_a}, 5'b11100);
      check("abort_data", data_a, 16'hFFFF);
      step();
      step();
      word_a = 16'h3C5A;
      push_a(16'h3C5A);
      falls = ld_falls_a;
      reset = 1'b1;
      wait_busy(0, 10, "busy_restart");
      ena_a = 1'b0;
      n = 0;
      while ((ld_falls_a == falls) && (n < 100)) begin
         step();
         n++;
      end
      check("restart_settle", ld_fall_cyc_a - busy_rise_a, SETTLE*DIV);
      wait_valid(0, FRAME1 + 50, "valid_restart_timeout");

      // Back-to-back frames (debounce sequence from a clean reset)
      reset = 1'b0;
      model_reset();
      step();
      reset = 1'b1;
      word_a = 16'h00FF;
      push_a(16'h00FF);
      push_a(16'h0F0F);
      push_a(16'h0F0F);
      ena_a = 1'b1;
      wait_valid(0, FRAME1 + 50, "valid_db1_timeout");
      word_a = 16'h0F0F;
      step();
      check("b2b_idle_gap", busy_a, 0);
      step();
      check("b2b_restart", busy_a, 1);
      wait_valid(0, FRAME1 + 50, "valid_db2_timeout");
      step();
      step();
      ena_a = 1'b0;
      wait_valid(0, FRAME1 + 50, "valid_db3_timeout");
      repeat (20) step();
      check("db_data_final", data_a, mdl_a);
      check("queue_a_empty", exp_q_a.size(), 0);
      check("queue_b_empty", exp_q_b.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
